// File: rtl/combo_key_sender.sv
// combo_key_sender: drives a keypad combo lock's io_in[5:0] field.
// Serialises four BCD digits as press/release key codes (digit d -> code d+1,
// 0000 between presses) and issues timed relock / master-reset pulses.
module combo_key_sender #(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  cmd,
  input  logic [15:0] digits,
  input  logic        abort,
  output logic [3:0]  key_code,
  output logic        relock_out,
  output logic        mreset_out,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int MaxCycles = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CntW      = $clog2(MaxCycles + 1);

  // Counters are loaded with N-1 and the phase ends when they reach zero,
  // which gives exactly N cycles per phase including the loading edge.
  localparam logic [CntW-1:0] HoldLoad = CntW'(HOLD_CYCLES - 1);
  localparam logic [CntW-1:0] GapLoad  = CntW'(GAP_CYCLES - 1);

  localparam logic [1:0] CmdCombo  = 2'b00;
  localparam logic [1:0] CmdMreset = 2'b01;
  localparam logic [1:0] CmdRelock = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    PRESS,
    GAP,
    PULSE,
    PGAP
  } state_t;

  state_t            state_q;
  logic [CntW-1:0]   cnt_q;
  logic [1:0]        idx_q;
  logic [15:0]       digits_q;
  logic [3:0]        key_code_q;
  logic              relock_q;
  logic              mreset_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;

  logic [1:0]        idx_d;
  logic [3:0]        nextCode;
  logic              digitsValid;
  logic [3:0]        firstCode;

  // A nibble is a legal digit only when it is 0..9; all four must be legal.
  assign digitsValid = (digits[3:0]   <= 4'd9) && (digits[7:4]   <= 4'd9) &&
                       (digits[11:8]  <= 4'd9) && (digits[15:12] <= 4'd9);

  // Codes on the bus are digit+1 so that digit 0 is distinguishable from release.
  assign firstCode = digits[3:0] + 4'd1;
  assign idx_d     = idx_q + 2'd1;
  assign nextCode  = digits_q[{idx_d, 2'b00} +: 4] + 4'd1;

  // Single sequencer: state, counters, latched digits and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= 2'd0;
      digits_q   <= 16'h0000;
      key_code_q <= 4'd0;
      relock_q   <= 1'b0;
      mreset_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (state_q != IDLE && abort) begin
        state_q    <= IDLE;
        cnt_q      <= '0;
        idx_q      <= 2'd0;
        key_code_q <= 4'd0;
        relock_q   <= 1'b0;
        mreset_q   <= 1'b0;
        busy_q     <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start && !abort) begin
              case (cmd)
                CmdCombo: begin
                  if (digitsValid) begin
                    digits_q   <= digits;
                    idx_q      <= 2'd0;
                    key_code_q <= firstCode;
                    busy_q     <= 1'b1;
                    cnt_q      <= HoldLoad;
                    state_q    <= PRESS;
                  end else begin
                    err_q <= 1'b1;
                  end
                end
                CmdMreset: begin
                  mreset_q <= 1'b1;
                  busy_q   <= 1'b1;
                  cnt_q    <= HoldLoad;
                  state_q  <= PULSE;
                end
                CmdRelock: begin
                  relock_q <= 1'b1;
                  busy_q   <= 1'b1;
                  cnt_q    <= HoldLoad;
                  state_q  <= PULSE;
                end
                default: begin
                  err_q <= 1'b1;
                end
              endcase
            end
          end
          PRESS: begin
            if (cnt_q == '0) begin
              key_code_q <= 4'd0;
              cnt_q      <= GapLoad;
              state_q    <= GAP;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          GAP: begin
            if (cnt_q == '0) begin
              if (idx_q != 2'd3) begin
                idx_q      <= idx_d;
                key_code_q <= nextCode;
                cnt_q      <= HoldLoad;
                state_q    <= PRESS;
              end else begin
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                idx_q   <= 2'd0;
                state_q <= IDLE;
              end
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          PULSE: begin
            if (cnt_q == '0) begin
              relock_q <= 1'b0;
              mreset_q <= 1'b0;
              cnt_q    <= GapLoad;
              state_q  <= PGAP;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          PGAP: begin
            if (cnt_q == '0) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= IDLE;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign key_code   = key_code_q;
  assign relock_out = relock_q;
  assign mreset_out = mreset_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_combo_key_sender.sv
// tb_combo_key_sender: table-driven directed checks of combo_key_sender
// with HOLD_CYCLES = GAP_CYCLES = 4, plus hand sequences for reset/abort.
module tb_combo_key_sender;

  localparam int H = 4;
  localparam int G = 4;

  logic        clk;
  logic        rstN;
  logic        start;
  logic [1:0]  cmd;
  logic [15:0] digits;
  logic        abort;
  logic [3:0]  keyCode;
  logic        relockOut;
  logic        mresetOut;
  logic        busy;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;

  // Observed outputs packed as {key_code, relock, mreset, busy, done, err}.
  logic [8:0] obs;
  assign obs = {keyCode, relockOut, mresetOut, busy, done, err};

  typedef struct {
    logic [1:0]  cmd;
    logic [15:0] digits;
    logic        expErr;
    logic [15:0] expCodes;
    int          pokeAt;
  } vec_t;

  vec_t vecs [0:8];

  combo_key_sender #(.HOLD_CYCLES(H), .GAP_CYCLES(G)) dut (
    .clk       (clk),
    .rst_n     (rstN),
    .start     (start),
    .cmd       (cmd),
    .digits    (digits),
    .abort     (abort),
    .key_code  (keyCode),
    .relock_out(relockOut),
    .mreset_out(mresetOut),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation exceeded time limit");
    $fatal(1, "[TB] timeout");
  end

  task automatic applyStimulus(input logic s, input logic [1:0] c,
                               input logic [15:0] d, input logic a);
    start  = s;
    cmd    = c;
    digits = d;
    abort  = a;
  endtask

  task automatic checkOutput(input string name, input logic [8:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got key=%b rl=%b mr=%b busy=%b done=%b err=%b, want key=%b rl=%b mr=%b busy=%b done=%b err=%b",
               name, obs[8:5], obs[4], obs[3], obs[2], obs[1], obs[0],
               exp[8:5], exp[4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  // Expected outputs e edges after the accept edge (e=0 is the accept edge).
  function automatic logic [8:0] expOut(input vec_t v, input int e);
    logic [8:0] r;
    int period;
    r = 9'b0;
    period = H + G;
    if (v.expErr) begin
      if (e == 0) r[0] = 1'b1;
    end else if (v.cmd == 2'b00) begin
      if (e < 4 * period) begin
        r[2] = 1'b1;
        if ((e % period) < H) r[8:5] = v.expCodes[(e / period) * 4 +: 4];
      end else if (e == 4 * period) begin
        r[1] = 1'b1;
      end
    end else begin
      if (e < period) begin
        r[2] = 1'b1;
        if (e < H) begin
          r[4] = (v.cmd == 2'b10);
          r[3] = (v.cmd == 2'b01);
        end
      end else if (e == period) begin
        r[1] = 1'b1;
      end
    end
    return r;
  endfunction

  task automatic runVector(input int id, input vec_t v);
    int last;
    last = v.expErr ? 1 : ((v.cmd == 2'b00) ? 4 * (H + G) + 1 : (H + G) + 1);
    @(negedge clk);
    applyStimulus(1'b1, v.cmd, v.digits, 1'b0);
    for (int e = 0; e <= last; e++) begin
      @(negedge clk);
      if (e == 0 || e == v.pokeAt + 1) applyStimulus(1'b0, 2'b00, 16'h0000, 1'b0);
      checkOutput($sformatf("vec%0d e%0d", id, e), expOut(v, e));
      if (e == v.pokeAt) applyStimulus(1'b1, 2'b00, 16'h5555, 1'b0);
    end
  endtask

  initial begin
    vecs[0] = '{cmd: 2'b00, digits: 16'h2907, expErr: 1'b0, expCodes: 16'h3A18, pokeAt: -1};
    vecs[1] = '{cmd: 2'b00, digits: 16'h12A4, expErr: 1'b1, expCodes: 16'h0000, pokeAt: -1};
    vecs[2] = '{cmd: 2'b11, digits: 16'h0000, expErr: 1'b1, expCodes: 16'h0000, pokeAt: -1};
    vecs[3] = '{cmd: 2'b01, digits: 16'h0000, expErr: 1'b0, expCodes: 16'h0000, pokeAt: -1};
    vecs[4] = '{cmd: 2'b10, digits: 16'h0000, expErr: 1'b0, expCodes: 16'h0000, pokeAt: -1};
    vecs[5] = '{cmd: 2'b00, digits: 16'h0000, expErr: 1'b0, expCodes: 16'h1111, pokeAt: -1};
    vecs[6] = '{cmd: 2'b00, digits: 16'h9999, expErr: 1'b0, expCodes: 16'hAAAA, pokeAt: -1};
    vecs[7] = '{cmd: 2'b00, digits: 16'h0F00, expErr: 1'b1, expCodes: 16'h0000, pokeAt: -1};
    vecs[8] = '{cmd: 2'b00, digits: 16'h2907, expErr: 1'b0, expCodes: 16'h3A18, pokeAt: 6};

    applyStimulus(1'b0, 2'b00, 16'h0000, 1'b0);
    rstN = 1'b0;
    #12;
    checkOutput("reset state", 9'b0);
    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
    checkOutput("idle after reset", 9'b0);

    for (int i = 0; i <= 8; i++) begin
      runVector(i, vecs[i]);
    end

    // Asynchronous reset in the middle of a press of code 0011.
    @(negedge clk);
    applyStimulus(1'b1, 2'b00, 16'h0002, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 2'b00, 16'h0000, 1'b0);
    checkOutput("press before reset", {4'b0011, 5'b00100});
    @(negedge clk);
    #2 rstN = 1'b0;
    #1 checkOutput("async reset mid press", 9'b0);
    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
    checkOutput("idle after mid reset", 9'b0);

    // Abort during the third press, with a busy-time start on the same cycle.
    @(negedge clk);
    applyStimulus(1'b1, 2'b00, 16'h2907, 1'b0);
    for (int e = 0; e <= 17; e++) begin
      @(negedge clk);
      if (e == 0) applyStimulus(1'b0, 2'b00, 16'h0000, 1'b0);
    end
    checkOutput("third press before abort", {4'b1010, 5'b00100});
    applyStimulus(1'b1, 2'b01, 16'h0000, 1'b1);
    @(negedge clk);
    applyStimulus(1'b0, 2'b00, 16'h0000, 1'b0);
    checkOutput("abort result", 9'b0);
    for (int e = 0; e < 20; e++) begin
      @(negedge clk);
      checkOutput($sformatf("after abort %0d", e), 9'b0);
    end

    // Abort and start together in IDLE: abort wins, nothing starts.
    applyStimulus(1'b1, 2'b00, 16'h2907, 1'b1);
    @(negedge clk);
    applyStimulus(1'b0, 2'b00, 16'h0000, 1'b0);
    checkOutput("idle abort+start", 9'b0);
    @(negedge clk);
    checkOutput("idle abort+start next", 9'b0);

    // Abort alone in IDLE is harmless; a pulse still runs normally afterwards.
    applyStimulus(1'b0, 2'b00, 16'h0000, 1'b1);
    @(negedge clk);
    applyStimulus(1'b0, 2'b00, 16'h0000, 1'b0);
    checkOutput("idle abort only", 9'b0);
    runVector(99, vecs[4]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
